// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the instruction-fetch
// port and the data (load/store) port. Accesses are serialised through an
// IDLE/ACCESS/DONE state machine; each access ends with a one-cycle ack carrying
// registered read data.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise data has fixed priority over inst.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_ack,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wen,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  // Counter preload: ACCESS lasts MEM_LATENCY cycles, the last one with cnt == 0.
  localparam logic [3:0] CntInit = 4'(MEM_LATENCY - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  win_data_q, win_data_d;  // 1 = current access belongs to data port
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  grant_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_data_q, last_data_d;  // 1 = data was served last

  // Round-robin grant: a lone request wins; on collision the one not served last wins.
  always_comb begin
    grant_data = data_req & (~inst_req | ~last_data_q);
  end

  // Last-served pointer; resets to "inst last served" so data wins the first collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end

  // Pointer follows every grant taken in IDLE.
  always_comb begin
    last_data_d = last_data_q;
    if (state_q == StIdle && (inst_req || data_req)) begin
      last_data_d = grant_data;
    end
  end
`else
  // Fixed priority grant: data always beats inst.
  always_comb begin
    grant_data = data_req;
  end
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      win_data_q   <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_data_q   <= win_data_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Next-state logic: launch in IDLE, count latency in ACCESS, ack in DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_data_d   = win_data_q;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (inst_req || data_req) begin
          win_data_d = grant_data;
          mem_cs_d   = 1'b1;
          cnt_d      = CntInit;
          state_d    = StAccess;
          if (grant_data) begin
            mem_we_d    = data_wen;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
          end else begin
            // Fetches never write; the write-data bus simply keeps its last value.
            mem_we_d   = 1'b0;
            mem_addr_d = inst_addr;
          end
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!mem_we_q) begin
            if (win_data_q) begin
              data_rdata_d = mem_rdata;
            end else begin
              inst_rdata_d = mem_rdata;
            end
          end
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: acks are decoded from DONE so a reset edge removes them immediately.
  always_comb begin
    inst_ack   = (state_q == StDone) && !win_data_q;
    data_ack   = (state_q == StDone) && win_data_q;
    busy       = (state_q != StIdle);
    mem_cs     = mem_cs_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    inst_rdata = inst_rdata_q;
    data_rdata = data_rdata_q;
  end

endmodule
